// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM write engine: command encodings, FSM states
// and the precharge-all address constant.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PALL  = 4'b0010;

    // A10 alone selects all banks on PRECHARGE.
    localparam logic [15:0] PALL_ADDR = 16'h0400;

    localparam int CNT_W = 8;

    typedef enum logic [7:0] {
        ST_IDLE  = 8'b0000_0001,
        ST_REQ   = 8'b0000_0010,
        ST_ACT   = 8'b0000_0100,
        ST_TRCD  = 8'b0000_1000,
        ST_WRITE = 8'b0001_0000,
        ST_TWR   = 8'b0010_0000,
        ST_PRE   = 8'b0100_0000,
        ST_TRP   = 8'b1000_0000
    } wr_state_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Row/column/remaining-burst counters for the write engine; a step advances one
// burst and rolls the row when the column wraps.
module sdram_addr_gen #(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 9,
    parameter int LEN_W     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] col_i,
    input  logic [LEN_W-1:0] num_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             row_end_o,
    output logic             last_o
);

    localparam logic [COL_W-1:0] COL_STEP = COL_W'(BURST_LEN);
    localparam logic [COL_W-1:0] COL_MASK = ~(COL_W'(BURST_LEN - 1));

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_nxt;
    logic [LEN_W-1:0] rem_q;

    assign col_nxt   = col_q + COL_STEP;
    assign row_end_o = (col_nxt == '0);
    assign last_o    = (rem_q == LEN_W'(1));
    assign row_o     = row_q;
    assign col_o     = col_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            row_q <= row_i;
            col_q <= col_i & COL_MASK;
            rem_q <= num_i;
        end else if (step_i) begin
            rem_q <= rem_q - LEN_W'(1);
            col_q <= col_nxt;
            if (row_end_o) begin
                row_q <= row_q + ROW_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_write_burst.sv
// SDRAM burst write engine: ACT / WRITE bursts / PALL under arbiter grant.
// IDLE wait trig | REQ ask bus | ACT open row | TRCD act->write | WRITE beats
// TWR write recovery | PRE precharge all | TRP precharge wait, then IDLE/REQ/ACT
module sdram_write_burst
    import sdram_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ROW_W     = 13,
    parameter int COL_W     = 9,
    parameter int BANK_W    = 2,
    parameter int ADDR_W    = 13,
    parameter int BURST_LEN = 4,
    parameter int LEN_W     = 16,
    parameter int TRCD_CYC  = 2,
    parameter int TWR_CYC   = 2,
    parameter int TRP_CYC   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              aref_req_i,
    input  logic              wr_en_i,
    input  logic              wr_trig_i,
    input  logic [BANK_W-1:0] wr_bank_i,
    input  logic [ROW_W-1:0]  wr_row_i,
    input  logic [COL_W-1:0]  wr_col_i,
    input  logic [LEN_W-1:0]  wr_burst_num_i,
    output logic              wr_req_o,
    output logic              wr_busy_o,
    output logic              flag_wr_end_o,
    output logic              flag_wr_done_o,
    output logic [3:0]        wr_cmd_o,
    output logic [BANK_W-1:0] wr_ba_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wfifo_rd_en_o,
    input  logic [DATA_W-1:0] wfifo_rd_data_i
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BURST_LEN);

    wr_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q;
    logic              done_q, aref_q;
    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BANK_W-1:0] ba_q;
    logic              flag_end_q, flag_done_q, busy_q;

    logic              load, step, exit_wr, zero_trig, trp_done;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col, col_wr;
    logic              row_end, last;

    sdram_addr_gen #(
        .ROW_W    (ROW_W),
        .COL_W    (COL_W),
        .LEN_W    (LEN_W),
        .BURST_LEN(BURST_LEN)
    ) u_addr_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .row_i    (wr_row_i),
        .col_i    (wr_col_i),
        .num_i    (wr_burst_num_i),
        .row_o    (row),
        .col_o    (col),
        .row_end_o(row_end),
        .last_o   (last)
    );

    // A back-to-back burst issues its WRITE on the same edge the counters step.
    assign col_wr = (state_q == ST_WRITE) ? col + COL_STEP : col;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        step      = 1'b0;
        exit_wr   = 1'b0;
        zero_trig = 1'b0;
        trp_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_trig_i) begin
                    if (wr_burst_num_i != '0) begin
                        load    = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        zero_trig = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (wr_en_i) state_d = ST_ACT;
            end
            ST_ACT: begin
                beat_d = '0;
                if (TRCD_CYC == 1) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_TRCD;
                    cnt_d   = CNT_W'(TRCD_CYC - 2);
                end
            end
            ST_TRCD: begin
                if (cnt_q == '0) state_d = ST_WRITE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_WRITE: begin
                if (beat_q == BEAT_LAST) begin
                    step   = 1'b1;
                    beat_d = '0;
                    if (last || aref_req_i || row_end) begin
                        exit_wr = 1'b1;
                        state_d = ST_TWR;
                        cnt_d   = CNT_W'(TWR_CYC - 1);
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_TWR: begin
                if (cnt_q == '0) state_d = ST_PRE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_PRE: begin
                if (TRP_CYC == 1) begin
                    trp_done = 1'b1;
                end else begin
                    state_d = ST_TRP;
                    cnt_d   = CNT_W'(TRP_CYC - 2);
                end
            end
            ST_TRP: begin
                if (cnt_q == '0) trp_done = 1'b1;
                else             cnt_d    = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (trp_done) begin
            state_d = done_q ? ST_IDLE : (aref_q ? ST_REQ : ST_ACT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            cnt_q       <= '0;
            bank_q      <= '0;
            done_q      <= 1'b0;
            aref_q      <= 1'b0;
            cmd_q       <= CMD_NOP;
            addr_q      <= ADDR_W'(PALL_ADDR);
            ba_q        <= '0;
            flag_end_q  <= 1'b0;
            flag_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != ST_IDLE);
            flag_end_q  <= (state_q == ST_PRE) && (done_q || aref_q);
            flag_done_q <= zero_trig || (trp_done && done_q);
            if (load) bank_q <= wr_bank_i;
            if (exit_wr) begin
                done_q <= last;
                aref_q <= aref_req_i;
            end
            cmd_q <= CMD_NOP;
            case (state_d)
                ST_ACT: begin
                    cmd_q  <= CMD_ACT;
                    addr_q <= ADDR_W'(row);
                    ba_q   <= bank_q;
                end
                ST_WRITE: begin
                    if (beat_d == '0) begin
                        cmd_q  <= CMD_WRITE;
                        addr_q <= ADDR_W'(col_wr);
                        ba_q   <= bank_q;
                    end
                end
                ST_PRE: begin
                    cmd_q  <= CMD_PALL;
                    addr_q <= ADDR_W'(PALL_ADDR);
                end
                default: ;
            endcase
        end
    end

    assign wr_req_o       = (state_q == ST_REQ);
    assign wr_busy_o      = busy_q;
    assign flag_wr_end_o  = flag_end_q;
    assign flag_wr_done_o = flag_done_q;
    assign wr_cmd_o       = cmd_q;
    assign wr_ba_o        = ba_q;
    assign wr_addr_o      = addr_q;
    assign wr_data_o      = wfifo_rd_data_i;
    assign wfifo_rd_en_o  = !rst_i && (state_d == ST_WRITE);

endmodule

// File: tb/tb_sdram_write_burst.sv
// Bench for sdram_write_burst: one narrow-column BL4 instance and one BL1
// instance with 3-bit rows and single-cycle timing.
module tb_sdram_write_burst;
    import sdram_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, aref, wr_en, trig, sel;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [3:0]  col;
    logic [15:0] num, fifo_data;

    logic        a_req, a_busy, a_end, a_done, a_rd;
    logic [3:0]  a_cmd;
    logic [1:0]  a_ba;
    logic [12:0] a_addr;
    logic [15:0] a_data;
    logic        b_req, b_busy, b_end, b_done, b_rd;
    logic [3:0]  b_cmd;
    logic [1:0]  b_ba;
    logic [10:0] b_addr;
    logic [15:0] b_data;

    logic        obs_req, obs_busy, obs_end, obs_done, obs_rd;
    logic [3:0]  obs_cmd;
    logic [1:0]  obs_ba;
    logic [12:0] obs_addr;
    logic [15:0] obs_data;

    sdram_write_burst #(
        .DATA_W(16), .ROW_W(13), .COL_W(4), .BANK_W(2), .ADDR_W(13), .BURST_LEN(4),
        .LEN_W(16), .TRCD_CYC(2), .TWR_CYC(2), .TRP_CYC(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .aref_req_i(aref), .wr_en_i(wr_en),
        .wr_trig_i(trig & ~sel), .wr_bank_i(bank), .wr_row_i(row), .wr_col_i(col),
        .wr_burst_num_i(num), .wr_req_o(a_req), .wr_busy_o(a_busy),
        .flag_wr_end_o(a_end), .flag_wr_done_o(a_done), .wr_cmd_o(a_cmd),
        .wr_ba_o(a_ba), .wr_addr_o(a_addr), .wr_data_o(a_data),
        .wfifo_rd_en_o(a_rd), .wfifo_rd_data_i(fifo_data)
    );

    sdram_write_burst #(
        .DATA_W(16), .ROW_W(3), .COL_W(2), .BANK_W(2), .ADDR_W(11), .BURST_LEN(1),
        .LEN_W(16), .TRCD_CYC(1), .TWR_CYC(1), .TRP_CYC(1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .aref_req_i(aref), .wr_en_i(wr_en),
        .wr_trig_i(trig & sel), .wr_bank_i(bank), .wr_row_i(row[2:0]), .wr_col_i(col[1:0]),
        .wr_burst_num_i(num), .wr_req_o(b_req), .wr_busy_o(b_busy),
        .flag_wr_end_o(b_end), .flag_wr_done_o(b_done), .wr_cmd_o(b_cmd),
        .wr_ba_o(b_ba), .wr_addr_o(b_addr), .wr_data_o(b_data),
        .wfifo_rd_en_o(b_rd), .wfifo_rd_data_i(fifo_data)
    );

    assign obs_req  = sel ? b_req  : a_req;
    assign obs_busy = sel ? b_busy : a_busy;
    assign obs_end  = sel ? b_end  : a_end;
    assign obs_done = sel ? b_done : a_done;
    assign obs_rd   = sel ? b_rd   : a_rd;
    assign obs_cmd  = sel ? b_cmd  : a_cmd;
    assign obs_ba   = sel ? b_ba   : a_ba;
    assign obs_addr = sel ? {2'b00, b_addr} : a_addr;
    assign obs_data = sel ? b_data : a_data;

    typedef struct {
        logic        trig, en;
        logic [3:0]  cmd;
        logic        ck_a;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic        req, rd, busy, fend, fdone;
    } vec_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } cmd_t;

    vec_t vt [15];
    cmd_t cmdq [$];
    cmd_t exp_q [$];
    int   wcyc [$];
    int   total = 0, bad = 0;
    int   n_rd, n_end, n_done, n_req, n_busy, last_done_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        mk = cmd_t'({c, b, a});
    endfunction

    // One transfer: trig in the first cycle, grant whenever requested and no
    // refresh is pending; refresh drops once the engine releases the bus.
    task automatic run(input int max_cyc, input int aref_at);
        int   cyc;
        logic seen, prev_req;
        int   done_cyc;
        cyc = 0; seen = 1'b0; prev_req = 1'b0; done_cyc = 0;
        cmdq.delete(); wcyc.delete();
        n_rd = 0; n_end = 0; n_done = 0; n_req = 0; n_busy = 0;
        while (cyc < max_cyc) begin
            trig = (cyc == 0);
            if (cyc == aref_at) aref = 1'b1;
            wr_en = obs_req && !aref;
            @(negedge clk);
            if (obs_cmd != CMD_NOP) begin
                cmdq.push_back(mk(obs_cmd, obs_ba, obs_addr));
                if (obs_cmd == CMD_WRITE) wcyc.push_back(cyc);
            end
            if (obs_rd) n_rd++;
            if (obs_busy) n_busy++;
            if (obs_req && !prev_req) n_req++;
            prev_req = obs_req;
            if (obs_end) begin
                n_end++;
                aref = 1'b0;
            end
            if (obs_done) begin
                n_done++;
                if (!seen) done_cyc = cyc;
                seen = 1'b1;
            end
            @(posedge clk); #1;
            if (seen && cyc >= done_cyc + 3) break;
            cyc++;
        end
        trig = 1'b0; wr_en = 1'b0; aref = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        last_done_cyc = done_cyc;
    endtask

    task automatic check_cmds(input string tag);
        chk({tag, ".ncmd"}, 32'(cmdq.size()), 32'(exp_q.size()));
        for (int i = 0; i < cmdq.size() && i < exp_q.size(); i++)
            chk($sformatf("%s.cmd%0d", tag, i), 32'(cmdq[i]), 32'(exp_q[i]));
    endtask

    task automatic check_stats(input string tag, input int rd, input int fe, input int fd, input int rq);
        chk({tag, ".rd_en"}, 32'(n_rd), 32'(rd));
        chk({tag, ".wr_end"}, 32'(n_end), 32'(fe));
        chk({tag, ".wr_done"}, 32'(n_done), 32'(fd));
        chk({tag, ".req"}, 32'(n_req), 32'(rq));
    endtask

    initial begin
        logic found;
        int   k;
        rst = 1'b1; aref = 1'b0; wr_en = 1'b0; trig = 1'b0; sel = 1'b0;
        bank = 2'd1; row = 13'd5; col = 4'd0; num = 16'd1; fifo_data = 16'h5A3C;

        // 1 burst, bank 1, row 5, col 0: cycle-by-cycle expectations
        vt[0]  = '{H, L, CMD_NOP,   H, 13'h400, 2'd0, L, L, L, L, L};
        vt[1]  = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, H, L, H, L, L};
        vt[2]  = '{L, H, CMD_NOP,   L, 13'h000, 2'd0, H, L, H, L, L};
        vt[3]  = '{L, L, CMD_ACT,   H, 13'h005, 2'd1, L, L, H, L, L};
        vt[4]  = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, H, H, L, L};
        vt[5]  = '{L, L, CMD_WRITE, H, 13'h000, 2'd1, L, H, H, L, L};
        vt[6]  = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, H, H, L, L};
        vt[7]  = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, H, H, L, L};
        vt[8]  = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, L, H, L, L};
        vt[9]  = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, L, H, L, L};
        vt[10] = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, L, H, L, L};
        vt[11] = '{L, L, CMD_PALL,  H, 13'h400, 2'd1, L, L, H, L, L};
        vt[12] = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, L, H, H, L};
        vt[13] = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, L, L, L, H};
        vt[14] = '{L, L, CMD_NOP,   L, 13'h000, 2'd0, L, L, L, L, L};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            trig  = vt[i].trig;
            wr_en = vt[i].en;
            @(negedge clk);
            chk($sformatf("v%0d.cmd", i), 32'(obs_cmd), 32'(vt[i].cmd));
            chk($sformatf("v%0d.req", i), 32'(obs_req), 32'(vt[i].req));
            chk($sformatf("v%0d.rd_en", i), 32'(obs_rd), 32'(vt[i].rd));
            chk($sformatf("v%0d.busy", i), 32'(obs_busy), 32'(vt[i].busy));
            chk($sformatf("v%0d.end", i), 32'(obs_end), 32'(vt[i].fend));
            chk($sformatf("v%0d.done", i), 32'(obs_done), 32'(vt[i].fdone));
            if (vt[i].ck_a) begin
                chk($sformatf("v%0d.addr", i), 32'(obs_addr), 32'(vt[i].addr));
                chk($sformatf("v%0d.ba", i), 32'(obs_ba), 32'(vt[i].ba));
            end
            if (i == 5) chk("wr_data", 32'(obs_data), 32'h5A3C);
            @(posedge clk); #1;
        end

        // row crossing: col 8, 3 bursts on a 16-column row
        bank = 2'd2; row = 13'd7; col = 4'd8; num = 16'd3;
        run(200, -1);
        exp_q.delete();
        exp_q.push_back(mk(CMD_ACT,   2'd2, 13'd7));
        exp_q.push_back(mk(CMD_WRITE, 2'd2, 13'd8));
        exp_q.push_back(mk(CMD_WRITE, 2'd2, 13'd12));
        exp_q.push_back(mk(CMD_PALL,  2'd2, 13'h400));
        exp_q.push_back(mk(CMD_ACT,   2'd2, 13'd8));
        exp_q.push_back(mk(CMD_WRITE, 2'd2, 13'd0));
        exp_q.push_back(mk(CMD_PALL,  2'd2, 13'h400));
        check_cmds("rowx");
        check_stats("rowx", 12, 1, 1, 1);

        // refresh raised during burst 2 of 5
        bank = 2'd3; row = 13'd10; col = 4'd0; num = 16'd5;
        run(300, 9);
        exp_q.delete();
        exp_q.push_back(mk(CMD_ACT,   2'd3, 13'd10));
        exp_q.push_back(mk(CMD_WRITE, 2'd3, 13'd0));
        exp_q.push_back(mk(CMD_WRITE, 2'd3, 13'd4));
        exp_q.push_back(mk(CMD_PALL,  2'd3, 13'h400));
        exp_q.push_back(mk(CMD_ACT,   2'd3, 13'd10));
        exp_q.push_back(mk(CMD_WRITE, 2'd3, 13'd8));
        exp_q.push_back(mk(CMD_WRITE, 2'd3, 13'd12));
        exp_q.push_back(mk(CMD_PALL,  2'd3, 13'h400));
        exp_q.push_back(mk(CMD_ACT,   2'd3, 13'd11));
        exp_q.push_back(mk(CMD_WRITE, 2'd3, 13'd0));
        exp_q.push_back(mk(CMD_PALL,  2'd3, 13'h400));
        check_cmds("aref");
        check_stats("aref", 20, 2, 1, 2);

        // zero-length trigger
        num = 16'd0;
        run(20, -1);
        chk("zero.ncmd", 32'(cmdq.size()), 32'd0);
        chk("zero.done_cyc", 32'(last_done_cyc), 32'd1);
        chk("zero.busy", 32'(n_busy), 32'd0);
        check_stats("zero", 0, 0, 1, 0);

        // reset during WRITE beat 2
        bank = 2'd0; row = 13'd3; col = 4'd0; num = 16'd2;
        trig = 1'b1; found = 1'b0; k = 0;
        while (!found && k < 30) begin
            wr_en = obs_req;
            @(negedge clk);
            if (obs_cmd == CMD_WRITE) found = 1'b1;
            @(posedge clk); #1;
            trig = 1'b0;
            k++;
        end
        wr_en = 1'b0;
        chk("rst.seek", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst.cmd", 32'(obs_cmd), 32'(CMD_NOP));
        chk("rst.busy", 32'(obs_busy), 32'd0);
        chk("rst.rd_en", 32'(obs_rd), 32'd0);
        chk("rst.addr", 32'(obs_addr), 32'h400);
        @(posedge clk); #1;
        bank = 2'd2; row = 13'd9; col = 4'd4; num = 16'd1;
        run(100, -1);
        exp_q.delete();
        exp_q.push_back(mk(CMD_ACT,   2'd2, 13'd9));
        exp_q.push_back(mk(CMD_WRITE, 2'd2, 13'd4));
        exp_q.push_back(mk(CMD_PALL,  2'd2, 13'h400));
        check_cmds("post_rst");
        check_stats("post_rst", 4, 1, 1, 1);

        // BL1, single-cycle timings, row wrap 7 -> 0
        sel = 1'b1;
        bank = 2'd1; row = 13'd7; col = 4'd2; num = 16'd3;
        run(100, -1);
        exp_q.delete();
        exp_q.push_back(mk(CMD_ACT,   2'd1, 13'd7));
        exp_q.push_back(mk(CMD_WRITE, 2'd1, 13'd2));
        exp_q.push_back(mk(CMD_WRITE, 2'd1, 13'd3));
        exp_q.push_back(mk(CMD_PALL,  2'd1, 13'h400));
        exp_q.push_back(mk(CMD_ACT,   2'd1, 13'd0));
        exp_q.push_back(mk(CMD_WRITE, 2'd1, 13'd0));
        exp_q.push_back(mk(CMD_PALL,  2'd1, 13'h400));
        check_cmds("bl1");
        check_stats("bl1", 3, 1, 1, 1);
        if (wcyc.size() >= 2) chk("bl1.b2b", 32'(wcyc[1] - wcyc[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
